// File: rtl/width_converter_nto8_pkg.sv
// Shared helpers for the TTI/I3C byte-count encoding used by the TX word path.
// The queue writer and the word-to-byte converter both use these.
package width_converter_nto8_pkg;

  // A count of 0 means "full word"; counts above the word size also mean a full word.
  function automatic int unsigned clamp_bytes(input int unsigned bytes,
                                              input int unsigned max_bytes);
    if ((bytes == 0) || (bytes > max_bytes)) begin
      return max_bytes;
    end
    return bytes;
  endfunction

endpackage

// File: rtl/width_converter_nto8.sv
// Unpacks Width-bit TX queue words into an LSB-first byte stream with a last-byte marker.
// A flush drops the rest of the held word.
module width_converter_nto8
  import width_converter_nto8_pkg::*;
#(
  parameter int Width = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               soft_reset_ni,
  input  logic               sink_valid_i,
  output logic               sink_ready_o,
  input  logic [Width-1:0]   sink_data_i,
  input  logic [$clog2(Width/8):0] sink_bytes_i,
  input  logic               sink_last_i,
  output logic               source_valid_o,
  input  logic               source_ready_i,
  output logic [7:0]         source_data_o,
  output logic               source_last_o,
  input  logic               source_flush_i
);

  localparam int unsigned Bytes  = Width / 8;
  localparam int unsigned BytesW = $clog2(Bytes);

  // Valid/ready: a transfer happens on a rising edge where valid and ready are both high.
  // The source side holds valid, data and last stable until the byte is taken or flushed.

  logic [Width-1:0]  r_sreg;
  logic [BytesW-1:0] r_idx;
  logic [BytesW:0]   r_rem;
  logic              r_last_q;

  logic              w_rem_one;
  logic              w_sink_hs;
  logic              w_source_hs;
  logic [BytesW:0]   w_load_rem;

  assign w_rem_one  = (r_rem == (BytesW + 1)'(1));
  assign w_load_rem = (BytesW + 1)'(clamp_bytes(32'(sink_bytes_i), Bytes));

  // Ready may rise while the final byte is being drained so words stream without a bubble.
  assign sink_ready_o   = !source_flush_i & ((r_rem == '0) | (w_rem_one & source_ready_i));
  assign source_valid_o = (r_rem != '0);
  assign source_data_o  = r_sreg[{r_idx, 3'b000} +: 8];
  assign source_last_o  = r_last_q & w_rem_one;

  assign w_sink_hs   = sink_valid_i & sink_ready_o;
  assign w_source_hs = source_valid_o & source_ready_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sreg   <= '0;
      r_idx    <= '0;
      r_rem    <= '0;
      r_last_q <= 1'b0;
    end else if (!soft_reset_ni || source_flush_i) begin
      r_sreg   <= '0;
      r_idx    <= '0;
      r_rem    <= '0;
      r_last_q <= 1'b0;
    end else if (w_sink_hs) begin
      // A load in the same cycle as the final-byte drain takes precedence.
      r_sreg   <= sink_data_i;
      r_idx    <= '0;
      r_rem    <= w_load_rem;
      r_last_q <= sink_last_i;
    end else if (w_source_hs) begin
      if (w_rem_one) begin
        // Clear the held word so an empty converter never shows stale bytes.
        r_sreg   <= '0;
        r_idx    <= '0;
        r_rem    <= '0;
        r_last_q <= 1'b0;
      end else begin
        r_idx <= r_idx + 1'b1;
        r_rem <= r_rem - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_width_converter_nto8.sv
// Bench for width_converter_nto8 (Width=32): table-driven words checked by a byte scoreboard,
// plus hand sequences for streaming, flush and both resets.
module tb_width_converter_nto8;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          soft_rst_n = 1'b1;
  logic          sink_valid = 1'b0;
  logic          sink_ready;
  logic [W-1:0]  sink_data = '0;
  logic [2:0]    sink_bytes = '0;
  logic          sink_last = 1'b0;
  logic          source_valid;
  logic          source_ready = 1'b0;
  logic [7:0]    source_data;
  logic          source_last;
  logic          flush = 1'b0;

  width_converter_nto8 #(.Width(W)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .soft_reset_ni  (soft_rst_n),
    .sink_valid_i   (sink_valid),
    .sink_ready_o   (sink_ready),
    .sink_data_i    (sink_data),
    .sink_bytes_i   (sink_bytes),
    .sink_last_i    (sink_last),
    .source_valid_o (source_valid),
    .source_ready_i (source_ready),
    .source_data_o  (source_data),
    .source_last_o  (source_last),
    .source_flush_i (flush)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- counters / check ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [8:0] exp_q[$];   // {last, byte}
  int         cur_exp_n = 0;
  int         cyc = 0;
  int         pop_count = 0;
  int         first_pop_cyc = 0;
  int         last_pop_cyc = 0;
  logic       stall_prev = 1'b0;
  logic [7:0] held_data = '0;
  logic       held_last = 1'b0;
  logic [8:0] e;

  // Inputs change only at posedge+1, so values seen at negedge are those sampled at the next posedge.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n || !soft_rst_n || flush) begin
      exp_q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", 32'(source_valid), 32'd1);
        chk("stall_data", 32'(source_data), 32'(held_data));
        chk("stall_last", 32'(source_last), 32'(held_last));
      end
      if (source_valid && source_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", 32'(source_data), 32'hxxxx_xxxx);
        end else begin
          e = exp_q.pop_front();
          chk("byte_data", 32'(source_data), 32'(e[7:0]));
          chk("byte_last", 32'(source_last), 32'(e[8]));
          if (pop_count == 0) first_pop_cyc = cyc;
          last_pop_cyc = cyc;
          pop_count++;
        end
      end
      if (sink_valid && sink_ready) begin
        for (int i = 0; i < cur_exp_n; i++) begin
          exp_q.push_back({(sink_last && (i == cur_exp_n - 1)), sink_data[8*i +: 8]});
        end
      end
      stall_prev = source_valid && !source_ready;
      held_data  = source_data;
      held_last  = source_last;
    end
  end

  // ---------------- drivers ----------------
  logic rand_ready = 1'b0;

  always @(posedge clk) begin
    #1;
    if (rand_ready) source_ready = ($urandom_range(0, 3) != 0);
  end

  // Called at posedge+1; returns at posedge+1 just after the accepting edge, valid still high.
  task automatic send_word(input logic [31:0] d, input logic [2:0] b, input logic l, input int n);
    int t = 0;
    sink_valid = 1'b1;
    sink_data  = d;
    sink_bytes = b;
    sink_last  = l;
    cur_exp_n  = n;
    @(negedge clk);
    while (!sink_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) chk("sink_timeout", 32'(t), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    sink_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    sink_valid = 1'b0;
    while (exp_q.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid"}, 32'(source_valid), 32'd0);
    chk({tag, "_data"},  32'(source_data),  32'd0);
    chk({tag, "_last"},  32'(source_last),  32'd0);
    chk({tag, "_ready"}, 32'(sink_ready),   32'd1);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [31:0] data;
    logic [2:0]  bytes;
    logic        last;
    int          exp_n;
  } vec_t;

  vec_t vecs[10];
  logic [31:0] exp_seq;

  initial begin
    vecs[0] = '{32'h4433_2211, 3'd4, 1'b1, 4};
    vecs[1] = '{32'hAABB_CCDD, 3'd3, 1'b1, 3};
    vecs[2] = '{32'hAABB_CCDD, 3'd0, 1'b1, 4};
    vecs[3] = '{32'h1234_5678, 3'd1, 1'b0, 1};
    vecs[4] = '{32'h9ABC_DEF0, 3'd2, 1'b1, 2};
    vecs[5] = '{32'h0F1E_2D3C, 3'd5, 1'b0, 4};
    vecs[6] = '{32'hCAFE_F00D, 3'd7, 1'b1, 4};
    vecs[7] = '{32'h8877_6655, 3'd4, 1'b0, 4};
    vecs[8] = '{32'h0000_0001, 3'd1, 1'b1, 1};
    vecs[9] = '{32'hFFEE_DDCC, 3'd3, 1'b0, 3};

    // Reset state
    #12;
    chk_reset_outputs("reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);
    chk_reset_outputs("post_reset");

    // Single full word, ready held high: 11,22,33,44 on consecutive cycles
    source_ready = 1'b1;
    send_word(32'h4433_2211, 3'd4, 1'b1, 4);
    sink_valid = 1'b0;
    exp_seq = 32'h4433_2211;
    for (int i = 0; i < 4; i++) begin
      chk("t1_valid", 32'(source_valid), 32'd1);
      chk("t1_data", 32'(source_data), 32'(exp_seq[8*i +: 8]));
      chk("t1_last", 32'(source_last), (i == 3) ? 32'd1 : 32'd0);
      if (i == 3) chk("t1_ready_on_last", 32'(sink_ready), 32'd1);
      @(posedge clk);
      #1;
    end
    chk("t1_empty", 32'(source_valid), 32'd0);
    wait_drain();

    // Two back-to-back words stream 8 bytes without a gap
    pop_count = 0;
    send_word(32'h4433_2211, 3'd4, 1'b0, 4);
    send_word(32'h8877_6655, 3'd4, 1'b1, 4);
    wait_drain();
    chk("t2_count", 32'(pop_count), 32'd8);
    chk("t2_span", 32'(last_pop_cyc - first_pop_cyc), 32'd7);

    // Table with random ready stalls and random gaps between words
    rand_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 10; i++) begin
        send_word(vecs[i].data, vecs[i].bytes, vecs[i].last, vecs[i].exp_n);
        idle($urandom_range(0, 2));
      end
    end
    wait_drain();
    rand_ready = 1'b0;
    source_ready = 1'b1;

    // Flush after 1 of 4 bytes
    send_word(32'h4433_2211, 3'd4, 1'b1, 4);
    sink_valid = 1'b0;
    @(posedge clk);
    #1;
    flush = 1'b1;
    #1;
    chk("flush_sink_ready", 32'(sink_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_valid", 32'(source_valid), 32'd0);
    chk("flush_data", 32'(source_data), 32'd0);
    send_word(32'hDEAD_BEEF, 3'd4, 1'b1, 4);
    chk("flush_next_byte0", 32'(source_data), 32'hEF);
    wait_drain();

    // Soft reset mid-word
    send_word(32'h5566_7788, 3'd4, 1'b1, 4);
    sink_valid = 1'b0;
    soft_rst_n = 1'b0;
    @(posedge clk);
    #1;
    soft_rst_n = 1'b1;
    chk_reset_outputs("soft");
    send_word(32'h0403_0201, 3'd4, 1'b1, 4);
    chk("soft_next_byte0", 32'(source_data), 32'h01);
    wait_drain();

    // Async reset mid-word: outputs clear without a clock edge
    send_word(32'h1122_3344, 3'd4, 1'b1, 4);
    sink_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("async");
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_word(32'hA1B2_C3D4, 3'd2, 1'b1, 2);
    chk("async_next_byte0", 32'(source_data), 32'hD4);
    wait_drain();
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
